// File: rtl/armleocpu_axi_pkg.sv
// Shared AXI4 encodings and controller state for the CLINT AXI register bridge.
//   RESP_*  : AXI response codes
//   BURST_* : burst types accepted for single-beat accesses
//   SIZE_4B : the only accepted transfer size (32-bit)
//   state_t : bridge FSM state encoding
//   axi_single_legal() : true when an AW/AR request is a plain aligned 32-bit single beat
package armleocpu_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_WSKIP  = 3'd2,
    ST_REG_WR = 3'd3,
    ST_BRESP  = 3'd4,
    ST_REG_RD = 3'd5,
    ST_RRESP  = 3'd6
  } state_t;

  function automatic logic axi_single_legal(input logic [7:0] len,
                                            input logic [2:0] size,
                                            input logic [1:0] burst,
                                            input logic [1:0] addr_lo);
    return (len == 8'd0) && (size == SIZE_4B) &&
           ((burst == BURST_FIXED) || (burst == BURST_INCR)) &&
           (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/armleocpu_clint_axi_ctrl.sv
// AXI4 slave that turns single-beat 32-bit transactions into a simple
// valid/ready register-port access. One transaction in flight at a time.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   AXI_AW* / AXI_W* / AXI_B*  : write address, data, response channels
//   AXI_AR* / AXI_R*     : read address and data channels
//   reg_valid/reg_write/reg_addr/reg_wdata/reg_wstrb : register request
//   reg_ready/reg_rdata/reg_err : register completion, read data, decode error
// Illegal requests (bursts, wrong size, WRAP, misaligned) answer SLVERR without
// touching the register port; a register access that is not acknowledged
// within TIMEOUT cycles is abandoned with SLVERR.
module armleocpu_clint_axi_ctrl
  import armleocpu_axi_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ID_WIDTH-1:0]   AXI_AWID,
  input  logic [ADDR_WIDTH-1:0] AXI_AWADDR,
  input  logic [7:0]            AXI_AWLEN,
  input  logic [2:0]            AXI_AWSIZE,
  input  logic [1:0]            AXI_AWBURST,
  input  logic                  AXI_AWVALID,
  output logic                  AXI_AWREADY,

  input  logic [31:0]           AXI_WDATA,
  input  logic [3:0]            AXI_WSTRB,
  input  logic                  AXI_WLAST,
  input  logic                  AXI_WVALID,
  output logic                  AXI_WREADY,

  output logic [ID_WIDTH-1:0]   AXI_BID,
  output logic [1:0]            AXI_BRESP,
  output logic                  AXI_BVALID,
  input  logic                  AXI_BREADY,

  input  logic [ID_WIDTH-1:0]   AXI_ARID,
  input  logic [ADDR_WIDTH-1:0] AXI_ARADDR,
  input  logic [7:0]            AXI_ARLEN,
  input  logic [2:0]            AXI_ARSIZE,
  input  logic [1:0]            AXI_ARBURST,
  input  logic                  AXI_ARVALID,
  output logic                  AXI_ARREADY,

  output logic [ID_WIDTH-1:0]   AXI_RID,
  output logic [31:0]           AXI_RDATA,
  output logic [1:0]            AXI_RRESP,
  output logic                  AXI_RLAST,
  output logic                  AXI_RVALID,
  input  logic                  AXI_RREADY,

  output logic                  reg_valid,
  output logic                  reg_write,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_wstrb,
  input  logic                  reg_ready,
  input  logic [31:0]           reg_rdata,
  input  logic                  reg_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  last_wr_q, last_wr_d;   // 1: last grant was a write
  logic [7:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            resp_q, resp_d;
  logic [31:0]           rdata_q, rdata_d;

  // Round-robin only matters when both channels request together.
  logic wr_grant;
  assign wr_grant    = AXI_AWVALID && (!AXI_ARVALID || !last_wr_q);
  // Gated by rst so the ready outputs are low during reset, not just after it.
  assign AXI_AWREADY = !rst && (state_q == ST_IDLE) && wr_grant;
  assign AXI_ARREADY = !rst && (state_q == ST_IDLE) && AXI_ARVALID && !wr_grant;
  assign AXI_WREADY  = (state_q == ST_WDATA) || (state_q == ST_WSKIP);

  assign AXI_BID     = id_q;
  assign AXI_BRESP   = resp_q;
  assign AXI_BVALID  = (state_q == ST_BRESP);
  assign AXI_RID     = id_q;
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = resp_q;
  assign AXI_RVALID  = (state_q == ST_RRESP);
  assign AXI_RLAST   = (state_q == ST_RRESP);

  assign reg_valid   = (state_q == ST_REG_WR) || (state_q == ST_REG_RD);
  assign reg_write   = (state_q == ST_REG_WR);
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wstrb   = wstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b0;
      cnt_q     <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (AXI_AWREADY) begin
          id_d      = AXI_AWID;
          addr_d    = AXI_AWADDR;
          last_wr_d = 1'b1;
          if (axi_single_legal(AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWADDR[1:0])) begin
            state_d = ST_WDATA;
          end else begin
            resp_d  = RESP_SLVERR;
            state_d = ST_WSKIP;
          end
        end else if (AXI_ARREADY) begin
          id_d      = AXI_ARID;
          addr_d    = AXI_ARADDR;
          last_wr_d = 1'b0;
          if (axi_single_legal(AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARADDR[1:0])) begin
            cnt_d   = '0;
            state_d = ST_REG_RD;
          end else begin
            resp_d  = RESP_SLVERR;
            rdata_d = '0;
            state_d = ST_RRESP;
          end
        end
      end
      ST_WDATA: begin
        if (AXI_WVALID) begin
          wdata_d = AXI_WDATA;
          wstrb_d = AXI_WSTRB;
          cnt_d   = '0;
          state_d = ST_REG_WR;
        end
      end
      // Drain the rejected burst so the W channel stays in step with AW.
      ST_WSKIP: begin
        if (AXI_WVALID && AXI_WLAST) state_d = ST_BRESP;
      end
      ST_REG_WR, ST_REG_RD: begin
        if (reg_ready) begin
          resp_d = reg_err ? RESP_DECERR : RESP_OKAY;
          if (state_q == ST_REG_RD) rdata_d = reg_rdata;
          state_d = (state_q == ST_REG_WR) ? ST_BRESP : ST_RRESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          state_d = (state_q == ST_REG_WR) ? ST_BRESP : ST_RRESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_BRESP: if (AXI_BREADY) state_d = ST_IDLE;
      ST_RRESP: if (AXI_RREADY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_armleocpu_clint_axi_ctrl.sv
// Randomized self-checking bench for armleocpu_clint_axi_ctrl. A transaction-level
// model predicts legality, response code, read data, register-port cycle count and
// response latency; a per-cycle monitor compares DUT outputs against it.
module tb_armleocpu_clint_axi_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  AXI_AWID = '0;  logic [15:0] AXI_AWADDR = '0;
  logic [7:0]  AXI_AWLEN = '0; logic [2:0]  AXI_AWSIZE = '0;
  logic [1:0]  AXI_AWBURST = '0; logic AXI_AWVALID = 1'b0; logic AXI_AWREADY;
  logic [31:0] AXI_WDATA = '0; logic [3:0] AXI_WSTRB = '0;
  logic        AXI_WLAST = 1'b0, AXI_WVALID = 1'b0; logic AXI_WREADY;
  logic [7:0]  AXI_BID; logic [1:0] AXI_BRESP; logic AXI_BVALID; logic AXI_BREADY = 1'b0;
  logic [7:0]  AXI_ARID = '0;  logic [15:0] AXI_ARADDR = '0;
  logic [7:0]  AXI_ARLEN = '0; logic [2:0]  AXI_ARSIZE = '0;
  logic [1:0]  AXI_ARBURST = '0; logic AXI_ARVALID = 1'b0; logic AXI_ARREADY;
  logic [7:0]  AXI_RID; logic [31:0] AXI_RDATA; logic [1:0] AXI_RRESP;
  logic        AXI_RLAST, AXI_RVALID; logic AXI_RREADY = 1'b0;
  logic        reg_valid, reg_write; logic [15:0] reg_addr;
  logic [31:0] reg_wdata; logic [3:0] reg_wstrb;
  logic        reg_ready = 1'b0, reg_err = 1'b0; logic [31:0] reg_rdata = '0;

  armleocpu_clint_axi_ctrl #(.ID_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .AXI_AWID(AXI_AWID), .AXI_AWADDR(AXI_AWADDR), .AXI_AWLEN(AXI_AWLEN),
    .AXI_AWSIZE(AXI_AWSIZE), .AXI_AWBURST(AXI_AWBURST), .AXI_AWVALID(AXI_AWVALID),
    .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BID(AXI_BID), .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARID(AXI_ARID), .AXI_ARADDR(AXI_ARADDR), .AXI_ARLEN(AXI_ARLEN),
    .AXI_ARSIZE(AXI_ARSIZE), .AXI_ARBURST(AXI_ARBURST), .AXI_ARVALID(AXI_ARVALID),
    .AXI_ARREADY(AXI_ARREADY),
    .AXI_RID(AXI_RID), .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RLAST(AXI_RLAST),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ready(reg_ready), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic        exp_act = 1'b0, exp_is_wr = 1'b0, exp_legal = 1'b0;
  logic [7:0]  exp_id = '0;  logic [15:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0, exp_rdata = '0; logic [3:0] exp_wstrb = '0;
  logic [1:0]  exp_resp = '0;
  int          exp_rv = 0, exp_lat = 0;
  int          slv_delay = 0; logic slv_err = 1'b0; logic [31:0] slv_rdata = '0;
  int          rv_cnt = 0, rv_total = 0;
  int          last_lat = 0, last_rv = 0;
  logic [1:0]  last_resp = '0; logic [7:0] last_id = '0; logic [31:0] last_rdata = '0;

  // Predict the whole outcome of one transaction from the protocol rules.
  task automatic model_setup(input logic wr, input logic [7:0] id, input logic [15:0] addr,
                             input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu,
                             input logic [31:0] wd, input logic [3:0] ws,
                             input int d, input logic err, input logic [31:0] rd);
    int dd;
    logic [15:0] a;
    a = addr;
    dd = (d > T - 1) ? T - 1 : d;
    exp_act   = 1'b1;
    exp_is_wr = wr;   exp_id = id; exp_addr = addr;
    exp_wdata = wd;   exp_wstrb = ws;
    exp_legal = (len == 0) && (sz == 3'd2) && (bu <= 2'd1) && (a[1:0] == 2'd0);
    if (!exp_legal)      exp_resp = 2'b10;
    else if (d > T - 1)  exp_resp = 2'b10;
    else if (err)        exp_resp = 2'b11;
    else                 exp_resp = 2'b00;
    exp_rdata = (!wr && exp_legal && d <= T - 1) ? rd : 32'h0;
    exp_rv    = exp_legal ? dd + 1 : 0;
    exp_lat   = exp_legal ? dd + 2 : 1;
    slv_delay = d; slv_err = err; slv_rdata = rd;
  endtask

  // Register-port responder: acknowledges after slv_delay cycles of reg_valid.
  always @(negedge clk) begin
    if (reg_valid) begin
      reg_ready = (rv_cnt == slv_delay);
      reg_err   = slv_err;
      reg_rdata = reg_ready ? slv_rdata : 32'hDEAD_BEEF;
      rv_cnt++;
      rv_total++;
    end else begin
      reg_ready = 1'b0;
      rv_cnt = 0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    #2;
    chk("ready_excl", AXI_AWREADY & AXI_ARREADY, 0);
    if (rst)
      chk("rst_zero", |{AXI_AWREADY, AXI_ARREADY, AXI_WREADY, AXI_BID, AXI_BRESP, AXI_BVALID,
                        AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID, reg_valid,
                        reg_write, reg_addr, reg_wdata, reg_wstrb}, 0);
    if (AXI_BVALID || AXI_RVALID)
      chk("ready_in_resp", AXI_AWREADY | AXI_ARREADY | AXI_WREADY, 0);
    if (exp_act && !rst) begin
      chk("rv_illegal", reg_valid && !exp_legal, 0);
      chk("b_on_read", AXI_BVALID && !exp_is_wr, 0);
      chk("r_on_write", AXI_RVALID && exp_is_wr, 0);
      if (reg_valid) begin
        chk("reg_write", reg_write, exp_is_wr);
        chk("reg_addr", reg_addr, exp_addr);
        if (exp_is_wr) begin
          chk("reg_wdata", reg_wdata, exp_wdata);
          chk("reg_wstrb", reg_wstrb, exp_wstrb);
        end
      end
      if (AXI_BVALID) begin
        chk("bid", AXI_BID, exp_id);
        chk("bresp", AXI_BRESP, exp_resp);
      end
      if (AXI_RVALID) begin
        chk("rid", AXI_RID, exp_id);
        chk("rresp", AXI_RRESP, exp_resp);
        chk("rdata", AXI_RDATA, exp_rdata);
        chk("rlast", AXI_RLAST, 1);
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0: return AXI_AWREADY;
      1: return AXI_ARREADY;
      2: return AXI_WREADY;
      3: return AXI_BVALID;
      4: return AXI_RVALID;
      5: return reg_valid;
      default: return 1'b0;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the signal was seen high.
  task automatic wait_hi(input int w, input string nm, output int c);
    int n;
    n = 0;
    c = -1;
    #1;
    while (!sig(w)) begin
      if (n >= 200) begin
        nchk++; nerr++;
        $display("FAIL %s: got timeout want signal high within 200 cycles", nm);
        return;
      end
      @(negedge clk); #1; n++;
    end
    c = cyc;
    @(negedge clk);
  endtask

  task automatic drive_aw(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
    AXI_AWID = id; AXI_AWADDR = a; AXI_AWLEN = len; AXI_AWSIZE = sz; AXI_AWBURST = bu;
    AXI_AWVALID = 1'b1;
  endtask

  task automatic drive_ar(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
    AXI_ARID = id; AXI_ARADDR = a; AXI_ARLEN = len; AXI_ARSIZE = sz; AXI_ARBURST = bu;
    AXI_ARVALID = 1'b1;
  endtask

  task automatic wr_rest(input int A, input logic [7:0] len, input int wgap, input int bdel,
                         input logic pend, input int rv0);
    int wc, bc, beats;
    wc = -1;
    repeat (wgap) @(negedge clk);
    beats = exp_legal ? 1 : int'(len) + 1;
    for (int b = 0; b < beats; b++) begin
      AXI_WDATA = exp_wdata ^ b; AXI_WSTRB = exp_wstrb; AXI_WLAST = (b == beats - 1);
      AXI_WVALID = 1'b1;
      wait_hi(2, "w_hs", wc);
    end
    AXI_WVALID = 1'b0; AXI_WLAST = 1'b0;
    wait_hi(3, "b_wait", bc);
    if (wc >= 0 && bc >= 0) chk("b_latency", bc - wc, exp_lat);
    last_lat = bc - A; last_resp = AXI_BRESP; last_id = AXI_BID;
    last_rv = rv_total - rv0;
    chk("rv_count", last_rv, exp_rv);
    for (int i = 0; i < bdel; i++) begin
      if (pend && i == 0) drive_aw(8'($urandom), 16'($urandom), 8'd0, 3'd2, 2'd1);
      @(negedge clk);
    end
    if (pend) AXI_AWVALID = 1'b0;
    AXI_BREADY = 1'b1;
    @(negedge clk);
    AXI_BREADY = 1'b0;
    #1 chk("b_drop", AXI_BVALID, 0);
  endtask

  task automatic rd_rest(input int A, input int bdel, input int rv0);
    int rc;
    wait_hi(4, "r_wait", rc);
    if (rc >= 0) chk("r_latency", rc - A, exp_lat);
    last_lat = rc - A; last_resp = AXI_RRESP; last_id = AXI_RID; last_rdata = AXI_RDATA;
    last_rv = rv_total - rv0;
    chk("rv_count", last_rv, exp_rv);
    repeat (bdel) @(negedge clk);
    AXI_RREADY = 1'b1;
    @(negedge clk);
    AXI_RREADY = 1'b0;
    #1 chk("r_drop", AXI_RVALID, 0);
  endtask

  task automatic run_wr(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bu, input logic [31:0] wd,
                        input logic [3:0] ws, input int d, input logic err, input int wgap,
                        input int bdel, input logic pend);
    int A, rv0;
    model_setup(1'b1, id, a, len, sz, bu, wd, ws, d, err, 32'h0);
    rv0 = rv_total;
    @(negedge clk);
    drive_aw(id, a, len, sz, bu);
    wait_hi(0, "aw_hs", A);
    AXI_AWVALID = 1'b0;
    wr_rest(A, len, wgap, bdel, pend, rv0);
  endtask

  task automatic run_rd(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bu, input int d,
                        input logic err, input logic [31:0] rd, input int bdel);
    int A, rv0;
    model_setup(1'b0, id, a, len, sz, bu, 32'h0, 4'h0, d, err, rd);
    rv0 = rv_total;
    @(negedge clk);
    drive_ar(id, a, len, sz, bu);
    wait_hi(1, "ar_hs", A);
    AXI_ARVALID = 1'b0;
    rd_rest(A, bdel, rv0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500us");
    $fatal(1);
  end

  initial begin
    int A, rv0, c;
    logic [15:0] a;
    logic [7:0] len; logic [2:0] sz; logic [1:0] bu;
    int d, r;

    // reset state
    repeat (3) @(negedge clk);
    #1 chk("reset_outs", |{AXI_AWREADY, AXI_ARREADY, AXI_WREADY, AXI_BVALID, AXI_RVALID,
                           AXI_RLAST, reg_valid, reg_write, reg_addr, reg_wdata, AXI_BID}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // single legal write, immediate ready
    run_wr(8'h5A, 16'h4000, 8'd0, 3'd2, 2'd1, 32'h1234_5678, 4'hF, 0, 1'b0, 0, 0, 1'b0);
    chk("wr_lat3", last_lat, 3);
    chk("wr_bresp_okay", last_resp, 2'b00);
    chk("wr_bid", last_id, 8'h5A);

    // single legal read, immediate ready
    run_rd(8'h3C, 16'h4008, 8'd0, 3'd2, 2'd0, 0, 1'b0, 32'h89AB_CDEF, 0);
    chk("rd_lat2", last_lat, 2);
    chk("rd_rdata", last_rdata, 32'h89AB_CDEF);

    // simultaneous AW/AR: write, read, write
    model_setup(1'b1, 8'h11, 16'h0010, 8'd0, 3'd2, 2'd1, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h0);
    rv0 = rv_total;
    @(negedge clk);
    drive_aw(8'h11, 16'h0010, 8'd0, 3'd2, 2'd1);
    drive_ar(8'h22, 16'h0020, 8'd0, 3'd2, 2'd1);
    #1 chk("arb1_grant", {AXI_AWREADY, AXI_ARREADY}, 2'b10);
    wait_hi(0, "arb1_aw", A);
    drive_aw(8'h33, 16'h0030, 8'd0, 3'd2, 2'd0);
    wr_rest(A, 8'd0, 0, 0, 1'b0, rv0);
    chk("arb1_bid", last_id, 8'h11);
    model_setup(1'b0, 8'h22, 16'h0020, 8'd0, 3'd2, 2'd1, 32'h0, 4'h0, 1, 1'b0, 32'hCAFE_0022);
    rv0 = rv_total;
    chk("arb2_grant", {AXI_AWREADY, AXI_ARREADY}, 2'b01);
    wait_hi(1, "arb2_ar", A);
    AXI_ARVALID = 1'b0;
    rd_rest(A, 0, rv0);
    chk("arb2_rid", last_id, 8'h22);
    chk("arb2_rdata", last_rdata, 32'hCAFE_0022);
    model_setup(1'b1, 8'h33, 16'h0030, 8'd0, 3'd2, 2'd0, 32'h0BAD_F00D, 4'h3, 0, 1'b0, 32'h0);
    rv0 = rv_total;
    chk("arb3_grant", {AXI_AWREADY, AXI_ARREADY}, 2'b10);
    wait_hi(0, "arb3_aw", A);
    AXI_AWVALID = 1'b0;
    wr_rest(A, 8'd0, 0, 0, 1'b0, rv0);
    chk("arb3_bid", last_id, 8'h33);

    // illegal requests
    run_rd(8'h07, 16'h0040, 8'd3, 3'd2, 2'd1, 0, 1'b0, 32'h1111_1111, 0);
    chk("arlen3_rresp", last_resp, 2'b10);
    chk("arlen3_rdata", last_rdata, 32'h0);
    chk("arlen3_no_reg", last_rv, 0);
    run_wr(8'h08, 16'h0002, 8'd0, 3'd2, 2'd1, 32'h2222_2222, 4'hF, 0, 1'b0, 0, 0, 1'b0);
    chk("wmisal_bresp", last_resp, 2'b10);
    chk("wmisal_no_reg", last_rv, 0);

    // timeout and decode error
    run_rd(8'h66, 16'h0200, 8'd0, 3'd2, 2'd1, 200, 1'b0, 32'h3333_3333, 0);
    chk("to_rv16", last_rv, 16);
    chk("to_rresp", last_resp, 2'b10);
    chk("to_rdata", last_rdata, 32'h0);
    run_rd(8'h67, 16'h0204, 8'd0, 3'd2, 2'd1, 2, 1'b1, 32'h4444_4444, 0);
    chk("decerr_rresp", last_resp, 2'b11);

    // BREADY held low for 10 cycles with a new AW pending
    run_wr(8'h70, 16'h0300, 8'd0, 3'd2, 2'd1, 32'h5555_AAAA, 4'h0, 1, 1'b0, 0, 10, 1'b1);
    chk("bhold_bresp", last_resp, 2'b00);

    // W presented before AW must stall
    @(negedge clk);
    AXI_WDATA = 32'h7777_0000; AXI_WSTRB = 4'h5; AXI_WLAST = 1'b1; AXI_WVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("w_early_stall", AXI_WREADY, 0);
      @(negedge clk);
    end
    model_setup(1'b1, 8'h71, 16'h0304, 8'd0, 3'd2, 2'd1, 32'h7777_0000, 4'h5, 0, 1'b0, 32'h0);
    rv0 = rv_total;
    drive_aw(8'h71, 16'h0304, 8'd0, 3'd2, 2'd1);
    wait_hi(0, "wearly_aw", A);
    AXI_AWVALID = 1'b0;
    wr_rest(A, 8'd0, 0, 0, 1'b0, rv0);
    chk("wearly_lat3", last_lat, 3);

    // reset in the middle of a register write
    model_setup(1'b1, 8'h44, 16'h0100, 8'd0, 3'd2, 2'd1, 32'h0000_0001, 4'hF, 200, 1'b0, 32'h0);
    @(negedge clk);
    drive_aw(8'h44, 16'h0100, 8'd0, 3'd2, 2'd1);
    wait_hi(0, "rst_aw", A);
    AXI_AWVALID = 1'b0;
    AXI_WDATA = 32'h1; AXI_WSTRB = 4'hF; AXI_WLAST = 1'b1; AXI_WVALID = 1'b1;
    wait_hi(2, "rst_w", c);
    AXI_WVALID = 1'b0; AXI_WLAST = 1'b0;
    wait_hi(5, "rst_rv", c);
    #3 rst = 1'b1;
    #1 chk("rst_mid_outs", |{AXI_AWREADY, AXI_ARREADY, AXI_WREADY, AXI_BID, AXI_BRESP,
                             AXI_BVALID, AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID,
                             reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb}, 0);
    exp_act = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("rst_abandon", {AXI_BVALID, AXI_RVALID, reg_valid}, 0);
    end

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      r  = int'($urandom_range(0, 99));
      a  = 16'($urandom);
      if (r % 8 != 3) a[1:0] = 2'b00;
      len = (r % 8 == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
      sz  = (r % 8 == 1) ? 3'($urandom_range(0, 7)) : 3'd2;
      bu  = (r % 6 == 2) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      d   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T - 2, T + 3))
                                        : int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        run_wr(8'($urandom), a, len, sz, bu, $urandom, 4'($urandom), d,
               ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      else
        run_rd(8'($urandom), a, len, sz, bu, d, ($urandom_range(0, 3) == 0), $urandom,
               int'($urandom_range(0, 3)));
    end

    exp_act = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
